// File: rtl/pulse_stretch_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding.
package pulse_stretch_pkg;

  // 2-bit state encoding shared with the rest of the serial-multiplier slice
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DONE   = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

endpackage

// File: rtl/pulse_stretch_load_down_counter.sv
// Loadable down-counter with a registered "count equals one" flag.
module load_down_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  logic [WIDTH-1:0] count_nxt;

  // Load has priority over decrement
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (dec) begin
      count_nxt = count - WIDTH'(1);
    end
  end

  // Count register; is_one is registered alongside so it tracks count exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      is_one <= 1'b0;
    end else begin
      count  <= count_nxt;
      is_one <= (count_nxt == WIDTH'(1));
    end
  end

endmodule

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle trigger into a level held for len cycles, then pulses done.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned HOLDOFF = 2,
  parameter bit          RETRIG  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [WIDTH-1:0] len,
  output logic             level,
  output logic             busy,
  output logic             done,
  output logic             dropped
);

  localparam int unsigned      MAX_CNT   = (1 << WIDTH) - 1;
  localparam bit               HAS_HOLD  = (HOLDOFF != 0);
  localparam logic [WIDTH-1:0] HOLD_LOAD = WIDTH'(HOLDOFF);

  // Holdoff must be representable in the shared counter
  if (HOLDOFF > MAX_CNT) begin : g_holdoff_check
    $error("pulse_stretch: HOLDOFF does not fit in WIDTH bits");
  end

  state_t           state;
  state_t           state_nxt;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_count;
  logic             cnt_is_one;
  logic             drop_c;
  logic             len_zero_c;

  assign len_zero_c = (len == '0);

  // One counter serves both the ACTIVE hold and the HOLD gap
  load_down_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .is_one   (cnt_is_one)
  );

  // Next-state, counter control and drop detection
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = len;
    cnt_dec      = 1'b0;
    drop_c       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          if (len_zero_c) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_ACTIVE;
            cnt_load  = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (trig && RETRIG && !len_zero_c) begin
          cnt_load = 1'b1;
        end else if (trig && RETRIG) begin
          state_nxt = ST_DONE;
        end else begin
          drop_c = trig;
          if (cnt_is_one) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_dec = |cnt_count;
          end
        end
      end
      ST_DONE: begin
        drop_c = trig;
        if (HAS_HOLD) begin
          state_nxt    = ST_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        drop_c = trig;
        if (cnt_is_one) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_dec = |cnt_count;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered output decode of the state flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      level   <= (state == ST_ACTIVE);
      busy    <= (state != ST_IDLE);
      done    <= (state == ST_DONE);
      dropped <= drop_c;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench: two instances (RETRIG=0 and RETRIG=1) driven by the same stimulus.
module tb_pulse_stretch;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [4:0] len;
  logic       level0, busy0, done0, dropped0;
  logic       level1, busy1, done1, dropped1;

  int n_cmp = 0;
  int n_err = 0;

  // per-instance statistics of the last run
  int lvl_cnt   [2];
  int lvl_first [2];
  int dn_cnt    [2];
  int dn_first  [2];
  int bsy_cnt   [2];
  int drp_cnt   [2];

  pulse_stretch #(.WIDTH(5), .HOLDOFF(2), .RETRIG(1'b0)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .len     (len),
    .level   (level0),
    .busy    (busy0),
    .done    (done0),
    .dropped (dropped0)
  );

  pulse_stretch #(.WIDTH(5), .HOLDOFF(2), .RETRIG(1'b1)) u_dut_rt (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .len     (len),
    .level   (level1),
    .busy    (busy1),
    .done    (done1),
    .dropped (dropped1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle i drives trig=mask[i] into edge i; outputs sampled 1 time unit after edge i
  task automatic run_seq(input logic [63:0] mask, input int lenv, input int ncyc);
    logic [1:0] lv, bs, dn, dp;
    for (int d = 0; d < 2; d++) begin
      lvl_cnt[d] = 0; lvl_first[d] = -1; dn_cnt[d] = 0;
      dn_first[d] = -1; bsy_cnt[d] = 0; drp_cnt[d] = 0;
    end
    for (int i = 0; i < ncyc; i++) begin
      trig = mask[i];
      len  = 5'(lenv);
      @(posedge clk);
      #1;
      lv = {level1, level0};
      bs = {busy1, busy0};
      dn = {done1, done0};
      dp = {dropped1, dropped0};
      for (int d = 0; d < 2; d++) begin
        if (lv[d]) begin
          lvl_cnt[d]++;
          if (lvl_first[d] < 0) lvl_first[d] = i;
        end
        if (dn[d]) begin
          dn_cnt[d]++;
          if (dn_first[d] < 0) dn_first[d] = i;
        end
        if (bs[d]) bsy_cnt[d]++;
        if (dp[d]) drp_cnt[d]++;
      end
    end
    trig = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int d, input int e_lvl,
                             input int e_first, input int e_dn, input int e_dn_at,
                             input int e_bsy, input int e_drp);
    check({tag, "_level_cycles"}, lvl_cnt[d], e_lvl);
    check({tag, "_level_first"}, lvl_first[d], e_first);
    check({tag, "_done_count"}, dn_cnt[d], e_dn);
    check({tag, "_done_at"}, dn_first[d], e_dn_at);
    check({tag, "_busy_cycles"}, bsy_cnt[d], e_bsy);
    check({tag, "_dropped"}, drp_cnt[d], e_drp);
  endtask

  initial begin
    rst  = 1'b0;
    trig = 1'b0;
    len  = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_level", int'(level0), 0);
    check("reset_busy", int'(busy0), 0);
    check("reset_done", int'(done0), 0);
    check("reset_dropped", int'(dropped0), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset 4 cycles into a len=10 hold
    run_seq(64'h1, 10, 5);
    check("rst_mid_level_before", lvl_cnt[0], 4);
    rst = 1'b0;
    #1;
    check("rst_mid_level", int'(level0), 0);
    check("rst_mid_busy", int'(busy0), 0);
    check("rst_mid_level_rt", int'(level1), 0);
    #2;
    rst = 1'b1;
    run_seq(64'h0, 0, 15);
    check_stats("post_rst", 0, 0, -1, 0, -1, 0, 0);

    // 2: len=3 single trigger
    run_seq(64'h1, 3, 12);
    check_stats("len3", 0, 3, 1, 1, 4, 6, 0);
    check_stats("len3_rt", 1, 3, 1, 1, 4, 6, 0);

    // 3: len=0 goes straight to done
    run_seq(64'h1, 0, 10);
    check_stats("len0", 0, 0, -1, 1, 1, 3, 0);

    // 4: second trig two cycles into a len=5 hold
    run_seq(64'h5, 5, 14);
    check_stats("retrig0", 0, 5, 1, 1, 6, 8, 1);
    check_stats("retrig1", 1, 7, 1, 1, 8, 10, 0);

    // 5: trig during DONE and both HOLD cycles
    run_seq(64'h39, 2, 10);
    check_stats("drop_done_hold", 0, 2, 1, 1, 3, 5, 3);
    check_stats("drop_done_hold_rt", 1, 2, 1, 1, 3, 5, 3);

    // 5b: trig held high for 14 cycles with len=2
    run_seq(64'h3FFF, 2, 20);
    check_stats("held", 0, 6, 1, 3, 3, 15, 11);
    check_stats("held_rt", 1, 15, 1, 1, 16, 18, 0);

    // 6: maximum length, no wrap
    run_seq(64'h1, 31, 40);
    check_stats("len31", 0, 31, 1, 1, 32, 34, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
